ib_20_input_buffer: RTL and testbench
=====================================

// Module: ib_20_input_buffer
// PURPOSE
//  Per-port input buffer for the router at node 20. It feeds the routing-computation (RC) stage.
//  - Accepts flits from a neighbour link (or the local core) with a valid/ready handshake.
//  - Stores them in a DEPTH-entry first-word-fall-through FIFO.
//  - Presents the head flit to RC on data_out/valid_out and pops on rc_ready.
//  - Publishes its occupancy as pressure_out. Upstream routers' RC units read this value as N/E pressure.
// PARAMETERS
//  DEPTH     8   number of FIFO entries; must be a power of two
//  WIDTH     3   log2(DEPTH); pointer width; pressure/count width is WIDTH+1
//  DATASIZE  40  flit width in bits
// PORTS
//  ib_clk        in   1           single clock; all state updates on rising edge
//  rst           in   1           synchronous, active-high reset
//  data_in       in   DATASIZE    flit from upstream link
//  valid_in      in   1           data_in valid
//  ready_out     out  1           buffer can accept a flit this cycle (=!full)
//  data_out      out  DATASIZE    head flit to RC
//  valid_out     out  1           head flit valid (=!empty)
//  rc_ready      in   1           RC consumes head flit this cycle when valid_out=1
//  pressure_out  out  WIDTH+1     current occupancy, 0..DEPTH
//  overflow_err  out  1           sticky: valid_in seen while full
// BEHAVIOUR
//  - Reset (rst=1 at edge):
//    - wr_ptr, rd_ptr and count are set to 0; overflow_err is set to 0.
//    - Outputs after reset: valid_out=0, ready_out=1, pressure_out=0, data_out=0.
//    - Memory contents are not reset.
//  - push = valid_in & ready_out. On push, mem[wr_ptr] <= data_in and wr_ptr <= wr_ptr+1 (wraps modulo DEPTH).
//  - pop = valid_out & rc_ready. On pop, rd_ptr <= rd_ptr+1 (wraps modulo DEPTH).
//  - count update: +1 on push only; -1 on pop only; unchanged on push&pop or on neither.
//  - Flags: full = (count==DEPTH); empty = (count==0). All are derived from the registered count.
//  - Latency:
//    - A flit pushed in cycle t is visible on data_out/valid_out in cycle t+1.
//    - There is no same-cycle bypass.
//  - data_out = mem[rd_ptr] (combinational read of a registered array). It is held stable while valid_out=1 and rc_ready=0.
//  - data_out while empty: data_out = 0 (masked), so RC never sees stale flits.
//  - pressure_out = count, registered.
//    - Range 0..DEPTH; width WIDTH+1; never saturates past DEPTH.
//  - Full:
//    - ready_out=0 and no push takes place.
//    - A simultaneous pop still occurs. The next cycle has count=DEPTH-1 and ready_out=1.
//    - Full-cycle pop does not enable a same-cycle push.
//  - Empty: valid_out=0, and rc_ready is ignored (no pop, no pointer underflow).
//  - Simultaneous push&pop (neither full nor empty): both occur and count is unchanged.
//  - Overflow: valid_in=1 while full sets overflow_err=1. It stays 1 until reset, and the flit is dropped.
//  - Reset mid-operation: all queued flits are discarded. The next cycle shows the reset output values.
//  - Pointer arithmetic is WIDTH bits with natural wrap. Count is WIDTH+1 bits.
// STRUCTURE
//  - Shared package/header noc_20_defs: flit width, DEPTH/WIDTH defaults, direction encoding for RC, pressure width macro.
//  - One sub-module ib_20_fifo_mem: DEPTH x DATASIZE register array with a write port (we, waddr, wdata) and an async read port.
//  - Top level holds pointers, count, flags, handshake and overflow logic.
//  - The router top instantiates one ib_20_input_buffer per port (N, E, L). N/E pressure_out wire to the neighbours' RC.
// TESTING
//  1. Reset check: assert rst for 2 cycles with valid_in=1 -> valid_out=0, ready_out=1, pressure_out=0, overflow_err=0, data_out=0.
//  2. Single flit: push 40'hA5_0000_0001 at cycle t with rc_ready=0.
//     -> valid_out=1 and data_out=40'hA5_0000_0001 at t+1; pressure_out=1.
//     Then rc_ready=1 for one cycle -> valid_out=0, pressure_out=0.
//  3. Fill, then overflow: push 8 flits 1..8 with rc_ready=0 -> pressure_out=8, ready_out=0.
//     Then 9th valid_in -> overflow_err=1; the flit is dropped. Then drain -> data_out reads 1..8 in order.
//  4. Wrap-around: 20 flits streamed with valid_in=1 and rc_ready=1 every cycle.
//     -> pressure_out stays 1 after the first cycle. Output order is 1..20; no loss or duplication.
//  5. Full plus simultaneous pop: at count=8 drive valid_in=1 and rc_ready=1.
//     -> pop occurs and push is rejected; count=7 next cycle; ready_out=1.
//  6. Reset mid-stream: at count=5 assert rst for one cycle -> next cycle count=0, valid_out=0.
//     Then push 40'h1 -> data_out=40'h1 at the following cycle.

Source files
------------

// File: rtl/noc_20_defs.sv
// Shared definitions for the node-20 router: flit geometry, input-buffer
// defaults and the direction encoding consumed by routing computation.
package noc_20_defs;

  localparam int DATASIZE = 40;
  localparam int DEPTH    = 8;
  localparam int WIDTH    = 3;
  localparam int PRESS_W  = WIDTH + 1;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_L = 2'd2,
    DIR_X = 2'd3
  } dir_e;

  // Even parity over a flit; available to links that carry a parity bit.
  function automatic logic flit_parity(input logic [DATASIZE-1:0] flit);
    return ^flit;
  endfunction

endpackage

// File: rtl/ib_20_fifo_mem.sv
// DEPTH x DATASIZE register array: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module ib_20_fifo_mem
  import noc_20_defs::*;
#(
  parameter int P_DEPTH    = DEPTH,
  parameter int P_WIDTH    = WIDTH,
  parameter int P_DATASIZE = DATASIZE
) (
  input  logic                  ib_clk,
  input  logic                  we,
  input  logic [P_WIDTH-1:0]    waddr,
  input  logic [P_DATASIZE-1:0] wdata,
  input  logic [P_WIDTH-1:0]    raddr,
  output logic [P_DATASIZE-1:0] rdata
);

  logic [P_DATASIZE-1:0] r_mem [P_DEPTH];

  // Write the incoming flit into the addressed entry.
  always_ff @(posedge ib_clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/ib_20_input_buffer.sv
// Per-port first-word-fall-through input buffer for router node 20.
// Holds pointers, occupancy, handshake flags and the sticky overflow flag;
// the storage itself lives in ib_20_fifo_mem.
module ib_20_input_buffer
  import noc_20_defs::*;
#(
  parameter int P_DEPTH    = DEPTH,
  parameter int P_WIDTH    = WIDTH,
  parameter int P_DATASIZE = DATASIZE
) (
  input  logic                  ib_clk,
  input  logic                  rst,
  input  logic [P_DATASIZE-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic [P_DATASIZE-1:0] data_out,
  output logic                  valid_out,
  input  logic                  rc_ready,
  output logic [P_WIDTH:0]      pressure_out,
  output logic                  overflow_err
);

  localparam logic [P_WIDTH:0] L_DEPTH = (P_WIDTH + 1)'(P_DEPTH);

  logic [P_WIDTH-1:0]    r_wr_ptr;
  logic [P_WIDTH-1:0]    r_rd_ptr;
  logic [P_WIDTH:0]      r_count;
  logic                  r_overflow;
  logic [P_WIDTH:0]      w_count_nxt;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [P_DATASIZE-1:0] w_rdata;

  // Flags come only from the registered count, so a pop on a full cycle
  // cannot open the door for a push in that same cycle.
  assign w_full  = (r_count == L_DEPTH);
  assign w_empty = (r_count == {(P_WIDTH + 1){1'b0}});
  assign w_push  = valid_in & ~w_full;
  assign w_pop   = rc_ready & ~w_empty;

  ib_20_fifo_mem #(
    .P_DEPTH   (P_DEPTH),
    .P_WIDTH   (P_WIDTH),
    .P_DATASIZE(P_DATASIZE)
  ) u_mem (
    .ib_clk(ib_clk),
    .we    (w_push),
    .waddr (r_wr_ptr),
    .wdata (data_in),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );

  // Next occupancy: simultaneous push and pop cancel out.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + {{P_WIDTH{1'b0}}, 1'b1};
      2'b01:   w_count_nxt = r_count - {{P_WIDTH{1'b0}}, 1'b1};
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointer, occupancy and sticky overflow state with synchronous reset.
  always_ff @(posedge ib_clk) begin
    if (rst) begin
      r_wr_ptr   <= {P_WIDTH{1'b0}};
      r_rd_ptr   <= {P_WIDTH{1'b0}};
      r_count    <= {(P_WIDTH + 1){1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + {{(P_WIDTH - 1){1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + {{(P_WIDTH - 1){1'b0}}, 1'b1};
      end
      r_count <= w_count_nxt;
      if (valid_in && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Mask the head entry while empty so RC never observes a stale flit.
  always_comb begin
    if (w_empty) begin
      data_out = {P_DATASIZE{1'b0}};
    end else begin
      data_out = w_rdata;
    end
  end

  assign valid_out    = ~w_empty;
  assign ready_out    = ~w_full;
  assign pressure_out = r_count;
  assign overflow_err = r_overflow;

endmodule

// File: tb/tb_ib_20_input_buffer.sv
// Directed bench for ib_20_input_buffer with a queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_ib_20_input_buffer;

  logic        ib_clk = 1'b0;
  logic        rst = 1'b1;
  logic [39:0] data_in = 40'h0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [39:0] data_out;
  logic        valid_out;
  logic        rc_ready = 1'b0;
  logic [3:0]  pressure_out;
  logic        overflow_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  logic [39:0] q[$];
  bit          m_ovf = 1'b0;

  ib_20_input_buffer dut (
    .ib_clk      (ib_clk),
    .rst         (rst),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .rc_ready    (rc_ready),
    .pressure_out(pressure_out),
    .overflow_err(overflow_err)
  );

  always #5 ib_clk = ~ib_clk;

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most 8 flits with a sticky overflow bit.
  always @(posedge ib_clk) begin
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      bit do_push;
      bit do_pop;
      do_push = valid_in && (q.size() < 8);
      do_pop  = rc_ready && (q.size() > 0);
      if (valid_in && q.size() == 8) m_ovf = 1'b1;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(data_in);
    end
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge ib_clk) begin
    if (check_en) begin
      chk("m_valid_out", {39'h0, valid_out}, {39'h0, (q.size() != 0)});
      chk("m_ready_out", {39'h0, ready_out}, {39'h0, (q.size() != 8)});
      chk("m_pressure", {36'h0, pressure_out}, 40'(q.size()));
      chk("m_data_out", data_out, (q.size() != 0) ? q[0] : 40'h0);
      chk("m_overflow", {39'h0, overflow_err}, {39'h0, m_ovf});
    end
  end

  task automatic step(input logic v, input logic [39:0] d, input logic r, input logic rs);
    valid_in = v;
    data_in  = d;
    rc_ready = r;
    rst      = rs;
    @(posedge ib_clk);
    #1;
  endtask

  initial begin
    // 1. Reset with valid_in high
    step(1'b1, 40'hFF, 1'b0, 1'b1);
    step(1'b1, 40'hFF, 1'b0, 1'b1);
    check_en = 1'b1;
    chk("rst_valid", {39'h0, valid_out}, 40'h0);
    chk("rst_ready", {39'h0, ready_out}, 40'h1);
    chk("rst_pressure", {36'h0, pressure_out}, 40'h0);
    chk("rst_ovf", {39'h0, overflow_err}, 40'h0);
    chk("rst_data", data_out, 40'h0);

    // 2. Single flit
    step(1'b1, 40'hA5_0000_0001, 1'b0, 1'b0);
    chk("single_data", data_out, 40'hA5_0000_0001);
    chk("single_valid", {39'h0, valid_out}, 40'h1);
    chk("single_press", {36'h0, pressure_out}, 40'h1);
    step(1'b0, 40'h0, 1'b1, 1'b0);
    chk("single_pop_valid", {39'h0, valid_out}, 40'h0);
    chk("single_pop_press", {36'h0, pressure_out}, 40'h0);

    // 3. Fill, overflow, drain
    for (int i = 1; i <= 8; i++) step(1'b1, 40'(i), 1'b0, 1'b0);
    chk("fill_press", {36'h0, pressure_out}, 40'h8);
    chk("fill_ready", {39'h0, ready_out}, 40'h0);
    step(1'b1, 40'h99, 1'b0, 1'b0);
    chk("ovf_set", {39'h0, overflow_err}, 40'h1);
    chk("ovf_press", {36'h0, pressure_out}, 40'h8);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", data_out, 40'(i));
      step(1'b0, 40'h0, 1'b1, 1'b0);
    end
    chk("drain_empty", {36'h0, pressure_out}, 40'h0);
    chk("ovf_sticky", {39'h0, overflow_err}, 40'h1);

    // 4. Wrap-around streaming
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) begin
        chk("stream_order", data_out, 40'(i - 1));
        chk("stream_press", {36'h0, pressure_out}, 40'h1);
      end
      step(1'b1, 40'(i), 1'b1, 1'b0);
    end
    chk("stream_last", data_out, 40'd20);
    step(1'b0, 40'h0, 1'b1, 1'b0);
    chk("stream_done", {39'h0, valid_out}, 40'h0);

    // 5. Full plus simultaneous pop
    for (int i = 1; i <= 8; i++) step(1'b1, 40'(100 + i), 1'b0, 1'b0);
    step(1'b1, 40'h77, 1'b1, 1'b0);
    chk("fullpop_press", {36'h0, pressure_out}, 40'h7);
    chk("fullpop_ready", {39'h0, ready_out}, 40'h1);
    chk("fullpop_head", data_out, 40'd102);

    // 6. Reset mid-stream at count 5
    step(1'b0, 40'h0, 1'b1, 1'b0);
    step(1'b0, 40'h0, 1'b1, 1'b0);
    chk("pre_rst_press", {36'h0, pressure_out}, 40'h5);
    step(1'b1, 40'h55, 1'b0, 1'b1);
    chk("midrst_press", {36'h0, pressure_out}, 40'h0);
    chk("midrst_valid", {39'h0, valid_out}, 40'h0);
    chk("midrst_ovf", {39'h0, overflow_err}, 40'h0);
    chk("midrst_data", data_out, 40'h0);
    step(1'b1, 40'h1, 1'b0, 1'b0);
    chk("post_rst_data", data_out, 40'h1);
    chk("post_rst_press", {36'h0, pressure_out}, 40'h1);
    step(1'b0, 40'h0, 1'b1, 1'b0);
    step(1'b0, 40'h0, 1'b0, 1'b0);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
